beat_packer: RTL and testbench
==============================

# beat_packer

Width upsizer that sits directly downstream of the valid-registered handshake stage. It accepts a stream of narrow DATA_WD beats and assembles every RATIO consecutive beats into one wide word of DATA_WD*RATIO bits. The wide word is presented on a registered valid/ready output. The block sustains full input throughput: one accepted beat per cycle while the downstream keeps up.

## Interface

Parameters:
- DATA_WD, 8, width of one input beat in bits.
- RATIO, 4, beats per output word; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_in  input  1  input beat valid.
- data_in  input  DATA_WD  input beat.
- ready_in  output  1  block can accept a beat this cycle.
- valid_out  output  1  packed word valid; registered.
- data_out  output  DATA_WD*RATIO  packed word; registered.
- ready_out  input  1  downstream accepts the word.
- last_in  input  1  final beat of a packet; present only under BEAT_PACKER_LAST_EN.
- last_out  output  1  word closes a packet; present only under BEAT_PACKER_LAST_EN.
- keep_out  output  RATIO  slot-filled mask, bit i covers data_out[i*DATA_WD +: DATA_WD]; present only under BEAT_PACKER_LAST_EN.

## Operation

- fire_in = valid_in && ready_in; fire_out = valid_out && ready_out.
- ready_in = !valid_out || ready_out. This path is combinational from ready_out.
- Slot counter cnt has width $clog2(RATIO) and resets to 0. Each fire_in writes data_in into slot cnt.
- Slot 0 occupies the LSBs, so the first beat lands in data_out[DATA_WD-1:0].
- When fire_in hits slot RATIO-1:
  - valid_out is set on the next edge;
  - cnt wraps to 0.
- fire_out clears valid_out, unless the same cycle completes another word.
- A word only accepts writes while valid_out is low, or in the same cycle as fire_out.
- When a new beat is written into slot 0, slots 1..RATIO-1 are cleared to 0 in that same cycle. A partial word never carries stale data.
- Simultaneous fire_out and fire_in:
  - the output word is consumed;
  - the beat goes into slot 0 of the next word;
  - no bubble is inserted.
- A beat is never dropped or duplicated, and data_out stays stable while valid_out && !ready_out.
- Reset asserted mid-word:
  - partial contents are discarded;
  - cnt returns to 0;
  - valid_out drops immediately (asynchronous).

## Timing

- Reset values:
  - valid_out = 0, data_out = 0, cnt = 0;
  - last_out = 0, keep_out = 0;
  - ready_in = 1 (it follows from valid_out = 0).
- Latency: valid_out rises one cycle after the fire_in of the word's final beat.
- Throughput with ready_out held 1: one word every RATIO cycles, and ready_in stays 1 continuously.
- With ready_out low while valid_out is high, ready_in is 0. Input stalls without loss until ready_out rises.

## Configuration

- Macro: BEAT_PACKER_LAST_EN.
- Defined: last_in, last_out and keep_out exist.
  - A fire_in with last_in = 1 closes the word at its current slot. valid_out is set on the next edge and cnt returns to 0.
  - Unfilled slots read 0, and their keep_out bits are 0.
  - last_out = 1 for that word.
  - last_in on slot RATIO-1 gives keep_out all ones and last_out = 1.
  - Words closed by count alone give keep_out all ones and last_out = 0.
- Undefined: those three ports are absent. Every word holds exactly RATIO beats; there is no early close.

## Structure

- Shared package beat_pkg holds:
  - the function computing the counter width from RATIO;
  - the localparam bounds for legal RATIO values (RATIO_MIN = 2, RATIO_MAX = 16), checked by an elaboration-time assertion.
- No sub-module is needed. The slot counter, slot registers and output register are inline in beat_packer.

## Test plan

Configuration for all scenarios: DATA_WD = 8, RATIO = 4.

1. Beats 0x11, 0x22, 0x33, 0x44 back-to-back, ready_out = 1 -> one cycle after the 4th beat, valid_out = 1 with data_out = 0x44332211 for one cycle.
2. Eight beats 0x01..0x08 back-to-back, ready_out = 1 -> words 0x04030201 then 0x08070605, four cycles apart; ready_in never drops.
3. Word ready but ready_out = 0 for 3 cycles while valid_in = 1 with 0x55 -> ready_in = 0 and data_out held. On the cycle ready_out rises, the word is consumed and 0x55 is accepted into slot 0 in the same cycle.
4. Two beats 0xA1, 0xA2, then rst_n pulsed low -> valid_out = 0 and cnt = 0. The next beats 0xB1..0xB4 yield 0xB4B3B2B1 with no A residue.
5. With BEAT_PACKER_LAST_EN: beats 0xAA, then 0xBB with last_in = 1 -> data_out = 0x0000BBAA, keep_out = 4'b0011, last_out = 1. The next four beats yield keep_out = 4'b1111 and last_out = 0.

Source files
------------

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared RATIO bounds and counter-width helper for beat_packer
package beat_pkg;

    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 16;

    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - narrow-to-wide beat packer with registered valid/ready output
// Optional early packet close with keep/last under BEAT_PACKER_LAST_EN.
module beat_packer
    import beat_pkg::*;
#(
    parameter int DATA_WD = 8,
    parameter int RATIO   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [DATA_WD-1:0]         data_in,
    output logic                       ready_in,
`ifdef BEAT_PACKER_LAST_EN
    input  logic                       last_in,
    output logic                       last_out,
    output logic [RATIO-1:0]           keep_out,
`endif
    output logic                       valid_out,
    output logic [DATA_WD*RATIO-1:0]   data_out,
    input  logic                       ready_out
);

    localparam int CW = cnt_width(RATIO);
    localparam int OW = DATA_WD * RATIO;
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

    if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_ratio_check
        $error("beat_packer: RATIO outside legal range");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [OW-1:0] data_q, data_d;
    logic          fire_in, fire_out, close;

    assign ready_in = !valid_q || ready_out;
    assign fire_in  = valid_in && ready_in;
    assign fire_out = valid_q && ready_out;

`ifdef BEAT_PACKER_LAST_EN
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;

    assign close    = fire_in && ((cnt_q == LAST_SLOT) || last_in);
    assign keep_out = keep_q;
    assign last_out = last_q;
`else
    assign close    = fire_in && (cnt_q == LAST_SLOT);
`endif

    // The word register doubles as the assembly buffer: it only takes writes
    // while empty or in the cycle it is being consumed, so data_out stays stable.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef BEAT_PACKER_LAST_EN
        keep_d  = keep_q;
        last_d  = last_q;
`endif
        if (fire_out) begin
            valid_d = 1'b0;
        end
        if (fire_in) begin
            if (cnt_q == '0) begin
                data_d = '0;
`ifdef BEAT_PACKER_LAST_EN
                keep_d = '0;
`endif
            end
            for (int i = 0; i < RATIO; i++) begin
                if (cnt_q == CW'(i)) begin
                    data_d[i*DATA_WD +: DATA_WD] = data_in;
`ifdef BEAT_PACKER_LAST_EN
                    keep_d[i] = 1'b1;
`endif
                end
            end
            cnt_d = close ? '0 : cnt_q + CW'(1);
            if (close) begin
                valid_d = 1'b1;
            end
`ifdef BEAT_PACKER_LAST_EN
            last_d = close && last_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef BEAT_PACKER_LAST_EN
            keep_q  <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef BEAT_PACKER_LAST_EN
            keep_q  <= keep_d;
            last_q  <= last_d;
`endif
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - self-checking bench for beat_packer (DATA_WD=8, RATIO=4)
module tb_beat_packer;

    localparam int DW = 8;
    localparam int R  = 4;
`ifdef BEAT_PACKER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            ready_out = 1'b0;
    logic            last_in = 1'b0;
    logic            ready_in;
    logic            valid_out;
    logic [DW*R-1:0] data_out;
`ifdef BEAT_PACKER_LAST_EN
    logic            last_out;
    logic [R-1:0]    keep_out;
`endif

    beat_packer #(.DATA_WD(DW), .RATIO(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
`ifdef BEAT_PACKER_LAST_EN
        .last_in   (last_in),
        .last_out  (last_out),
        .keep_out  (keep_out),
`endif
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*R-1:0] word;
        logic [R-1:0]    keep;
        logic            last;
    } exp_t;

    typedef struct {
        logic            v;
        logic [DW-1:0]   d;
        logic            r;
        logic            exp_valid;
        logic [DW*R-1:0] exp_data;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int n_total = 0;
    int n_pass  = 0;

    logic            m_valid = 1'b0;
    int              m_cnt   = 0;
    logic [DW*R-1:0] m_word  = '0;
    logic [R-1:0]    m_keep  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_cnt   = 0;
        m_word  = '0;
        m_keep  = '0;
        sb.delete();
    endtask

    // One clock: drive at negedge, check 1ns later, advance the model to the next edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic l);
        logic m_ready;
        exp_t e;
        @(negedge clk);
        valid_in = v; data_in = d; ready_out = r; last_in = l;
        #1;
        m_ready = !m_valid || r;
        chk("ready_in", ready_in, m_ready);
        chk("valid_out", valid_out, m_valid);
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("data_out", data_out, sb[0].word);
`ifdef BEAT_PACKER_LAST_EN
                chk("keep_out", keep_out, sb[0].keep);
                chk("last_out", last_out, sb[0].last);
`endif
                if (r) void'(sb.pop_front());
            end
            if (r) m_valid = 1'b0;
        end
        if (v && m_ready) begin
            if (m_cnt == 0) begin
                m_word = '0;
                m_keep = '0;
            end
            m_word[m_cnt*DW +: DW] = d;
            m_keep[m_cnt] = 1'b1;
            if (m_cnt == R-1 || (LAST_EN && l)) begin
                e.word = m_word;
                e.keep = m_keep;
                e.last = LAST_EN && l;
                sb.push_back(e);
                m_valid = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic void add(input logic v, input logic [DW-1:0] d, input logic r,
                                input logic ev, input logic [DW*R-1:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.exp_valid = ev; t.exp_data = ed;
        tbl.push_back(t);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: single word
        add(1, 8'h11, 1, 0, '0);
        add(1, 8'h22, 1, 0, '0);
        add(1, 8'h33, 1, 0, '0);
        add(1, 8'h44, 1, 0, '0);
        add(0, 8'h00, 1, 1, 32'h44332211);
        add(0, 8'h00, 1, 0, '0);
        // Test 2: two words back-to-back
        for (int i = 1; i <= 8; i++)
            add(1, DW'(i), 1, (i == 5), (i == 5) ? 32'h04030201 : '0);
        add(0, 8'h00, 1, 1, 32'h08070605);
        add(0, 8'h00, 1, 0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ready_in", ready_in, 1);
`ifdef BEAT_PACKER_LAST_EN
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl_ready_in", ready_in, 1);
            chk("tbl_valid_out", valid_out, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk("tbl_data_out", data_out, tbl[i].exp_data);
        end

        // Test 3: downstream stall, then simultaneous consume and accept
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h03, 0, 0);
        cycle(1, 8'h04, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h55, 0, 0);
            chk("stall_ready_in", ready_in, 0);
            chk("stall_data_out", data_out, 32'h04030201);
        end
        cycle(1, 8'h55, 1, 0);
        chk("release_ready_in", ready_in, 1);
        cycle(1, 8'h66, 1, 0);
        chk("after_consume_valid", valid_out, 0);
        cycle(1, 8'h77, 1, 0);
        cycle(1, 8'h88, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t3_word", data_out, 32'h88776655);
        cycle(0, 8'h00, 1, 0);

        // Test 4: reset mid-word discards partial contents
        cycle(1, 8'hA1, 1, 0);
        cycle(1, 8'hA2, 1, 0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_data_out", data_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 8'hB1, 1, 0);
        cycle(1, 8'hB2, 1, 0);
        cycle(1, 8'hB3, 1, 0);
        cycle(1, 8'hB4, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t4_word", data_out, 32'hB4B3B2B1);
        cycle(0, 8'h00, 1, 0);

        // Asynchronous drop of a pending valid_out
        cycle(1, 8'hC1, 0, 0);
        cycle(1, 8'hC2, 0, 0);
        cycle(1, 8'hC3, 0, 0);
        cycle(1, 8'hC4, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("pending_valid", valid_out, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid_drop", valid_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BEAT_PACKER_LAST_EN
        // Test 5: early close with last_in
        cycle(1, 8'hAA, 1, 0);
        cycle(1, 8'hBB, 1, 1);
        cycle(0, 8'h00, 1, 0);
        chk("t5_data", data_out, 32'h0000BBAA);
        chk("t5_keep", keep_out, 4'b0011);
        chk("t5_last", last_out, 1);
        cycle(1, 8'h01, 1, 0);
        cycle(1, 8'h02, 1, 0);
        cycle(1, 8'h03, 1, 0);
        cycle(1, 8'h04, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("t5_full_keep", keep_out, 4'b1111);
        chk("t5_full_last", last_out, 0);
        // last on the final slot
        cycle(1, 8'h05, 1, 0);
        cycle(1, 8'h06, 1, 0);
        cycle(1, 8'h07, 1, 0);
        cycle(1, 8'h08, 1, 1);
        cycle(0, 8'h00, 1, 0);
        chk("t5_slot3_keep", keep_out, 4'b1111);
        chk("t5_slot3_last", last_out, 1);
`endif

        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
